// File: rtl/row_buffer_writer.sv
// Writes one full input-feature-map row (LAST_N channels x BUFFER_RAM_COUNT groups) into a row buffer.
// Optional `ROW_WRITER_RELU_EN clamps negative real pixels to zero on the way in.
module row_buffer_writer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned REAL_HINT  = 56,
  parameter int unsigned LAST_Iw    = 7,
  parameter int unsigned LAST_N     = 256,
  parameter int unsigned ADDR_WIDTH = 32,
  localparam int unsigned HINT             = ((REAL_HINT + LAST_Iw - 1) / LAST_Iw) * LAST_Iw,
  localparam int unsigned BUFFER_RAM_COUNT = HINT / LAST_Iw,
  localparam int unsigned BEAT_W           = LAST_Iw * DATA_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   buffer_writer_en,
  output logic                                   buffer_writer_done,
  output logic                                   busy,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [BEAT_W-1:0]                      in_data,
  output logic [BUFFER_RAM_COUNT-1:0]            buffer_writer_ram_wren,
  output logic [BUFFER_RAM_COUNT*ADDR_WIDTH-1:0] buffer_writer_ram_wr_addr,
  output logic [BUFFER_RAM_COUNT*BEAT_W-1:0]     buffer_writer_ram_wr_data
);

  localparam int unsigned G_W = (BUFFER_RAM_COUNT > 1) ? $clog2(BUFFER_RAM_COUNT) : 1;
  localparam int unsigned C_W = (LAST_N > 1) ? $clog2(LAST_N) : 1;

  typedef enum logic [1:0] {StIdle, StWrite, StFlush, StDone} state_e;

  state_e state_q, state_d;
  logic [G_W-1:0] g_q, g_d;
  logic [C_W-1:0] c_q, c_d;

  logic                                   accept, last_g, last_c;
  logic [BEAT_W-1:0]                      beat;
  logic [BUFFER_RAM_COUNT-1:0]            wren_d;
  logic [BUFFER_RAM_COUNT*ADDR_WIDTH-1:0] addr_d;
  logic [BUFFER_RAM_COUNT*BEAT_W-1:0]     data_d;
  logic                                   done_d, busy_d;

  assign in_ready = (state_q == StWrite);
  assign accept   = in_valid && in_ready;
  assign last_g   = (g_q == G_W'(BUFFER_RAM_COUNT - 1));
  assign last_c   = (c_q == C_W'(LAST_N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      g_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      c_q     <= c_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (buffer_writer_en) state_d = StWrite;
      StWrite: if (accept && last_g && last_c) state_d = StFlush;
      StFlush: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Channel-major walk: groups of one channel first, then the next channel.
  always_comb begin
    g_d = g_q;
    c_d = c_q;
    if (state_q == StIdle) begin
      g_d = '0;
      c_d = '0;
    end else if (accept) begin
      if (last_g) begin
        g_d = '0;
        c_d = last_c ? '0 : c_q + 1'b1;
      end else begin
        g_d = g_q + 1'b1;
      end
    end
  end

  always_comb begin
    logic [DATA_WIDTH-1:0] px;
    beat   = '0;
    wren_d = '0;
    addr_d = '0;
    data_d = '0;
    for (int unsigned k = 0; k < LAST_Iw; k++) begin
      px = in_data[k*DATA_WIDTH +: DATA_WIDTH];
`ifdef ROW_WRITER_RELU_EN
      if (px[DATA_WIDTH-1]) px = '0;
`endif
      // Lanes past the real row width are padding columns.
      if (32'(g_q) * LAST_Iw + k >= REAL_HINT) px = '0;
      beat[k*DATA_WIDTH +: DATA_WIDTH] = px;
    end
    for (int unsigned i = 0; i < BUFFER_RAM_COUNT; i++) begin
      if (accept && (32'(g_q) == i)) begin
        wren_d[i]                           = 1'b1;
        addr_d[i*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(c_q);
        data_d[i*BEAT_W +: BEAT_W]         = beat;
      end
    end
    done_d = (state_d == StDone);
    busy_d = (state_d == StWrite) || (state_d == StFlush);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buffer_writer_ram_wren    <= '0;
      buffer_writer_ram_wr_addr <= '0;
      buffer_writer_ram_wr_data <= '0;
      buffer_writer_done        <= 1'b0;
      busy                      <= 1'b0;
    end else begin
      buffer_writer_ram_wren    <= wren_d;
      buffer_writer_ram_wr_addr <= addr_d;
      buffer_writer_ram_wr_data <= data_d;
      buffer_writer_done        <= done_d;
      busy                      <= busy_d;
    end
  end

endmodule

// File: tb/tb_row_buffer_writer.sv
// Scoreboard bench: a small 10/4/2 instance for directed and random rows, a default instance
// for the full 2048-beat row.
module tb_row_buffer_writer;

  localparam int S_REAL = 10;
  localparam int S_IW   = 4;
  localparam int S_N    = 2;
  localparam int S_RC   = 3;
  localparam int F_RC   = 8;
  localparam int F_N    = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        en_s = 1'b0, valid_s = 1'b0;
  logic        done_s, busy_s, ready_s;
  logic [31:0] data_s = '0;
  logic [2:0]  wren_s;
  logic [95:0] addr_s, wdata_s;

  logic         f_en = 1'b0, f_valid = 1'b0;
  logic         f_done, f_busy, f_ready;
  logic [55:0]  f_data = '0;
  logic [7:0]   f_wren;
  logic [255:0] f_addr;
  logic [447:0] f_wdata;

  row_buffer_writer #(
    .DATA_WIDTH(8), .REAL_HINT(S_REAL), .LAST_Iw(S_IW), .LAST_N(S_N), .ADDR_WIDTH(32)
  ) dut_s (
    .clk                      (clk),
    .rst                      (rst),
    .buffer_writer_en         (en_s),
    .buffer_writer_done       (done_s),
    .busy                     (busy_s),
    .in_valid                 (valid_s),
    .in_ready                 (ready_s),
    .in_data                  (data_s),
    .buffer_writer_ram_wren   (wren_s),
    .buffer_writer_ram_wr_addr(addr_s),
    .buffer_writer_ram_wr_data(wdata_s)
  );

  row_buffer_writer dut_f (
    .clk                      (clk),
    .rst                      (rst),
    .buffer_writer_en         (f_en),
    .buffer_writer_done       (f_done),
    .busy                     (f_busy),
    .in_valid                 (f_valid),
    .in_ready                 (f_ready),
    .in_data                  (f_data),
    .buffer_writer_ram_wren   (f_wren),
    .buffer_writer_ram_wr_addr(f_addr),
    .buffer_writer_ram_wr_data(f_wdata)
  );

  typedef struct {
    int unsigned cyc;
    logic [2:0]  wren;
    logic [95:0] addr;
    logic [95:0] data;
  } wr_t;

  wr_t         exp_wr[$];
  int unsigned exp_done[$];
  logic [55:0] exp_fw[$];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] px_model(input logic [7:0] v, input int col, input int nreal);
    if (col >= nreal) return 8'h00;
`ifdef ROW_WRITER_RELU_EN
    if ($signed(v) < 0) return 8'h00;
`endif
    return v;
  endfunction

  // Small-instance monitor.
  always @(negedge clk) begin
    wr_t e;
    if (wren_s !== 3'b000) begin
      if (exp_wr.size() == 0) begin
        chk("unexpected write", 512'(wren_s), 512'(0));
      end else begin
        e = exp_wr.pop_front();
        chk("write cycle", 512'(cyc), 512'(e.cyc));
        chk("wren", 512'(wren_s), 512'(e.wren));
        chk("wr_addr", 512'(addr_s), 512'(e.addr));
        chk("wr_data", 512'(wdata_s), 512'(e.data));
      end
    end
    if (done_s === 1'b1) begin
      if (exp_done.size() == 0) begin
        chk("unexpected done", 512'(done_s), 512'(0));
      end else begin
        chk("done cycle", 512'(cyc), 512'(exp_done.pop_front()));
        chk("busy at done", 512'(busy_s), 512'(0));
      end
    end
  end

  // Default-instance monitor: per-RAM write counts double as expected addresses.
  int unsigned f_cnt[F_RC];
  int unsigned f_seen = 0;
  int unsigned f_done_cnt = 0;
  always @(negedge clk) begin
    int idx;
    idx = 0;
    if (f_wren !== 8'h00) begin
      chk("f wren onehot", 512'($onehot(f_wren)), 512'(1));
      for (int i = 0; i < F_RC; i++) if (f_wren[i]) idx = i;
      chk("f ram index", 512'(idx), 512'(f_seen % F_RC));
      chk("f addr", 512'(f_addr[idx*32 +: 32]), 512'(f_cnt[idx]));
      if (exp_fw.size() == 0) chk("f unexpected write", 512'(f_wren), 512'(0));
      else chk("f data", 512'(f_wdata[idx*56 +: 56]), 512'(exp_fw.pop_front()));
      f_cnt[idx]++;
      f_seen++;
    end
    if (f_done === 1'b1) f_done_cnt++;
  end

  // mode: 0 lane-incrementing, 1 random, 2 ReLU pattern.
  // gap_mode: 0 back-to-back, 1 alternate valid, 2 random gaps.
  task automatic run_row(input int mode, input int gap_mode, input int en_at, input int n_beats,
                         input bit en_in_done);
    logic [7:0]  relu_pat[4];
    logic [7:0]  lane;
    logic [31:0] beat, word;
    int          g, c, gap, tmo;
    wr_t         e;
    relu_pat = '{8'h80, 8'hFF, 8'h7F, 8'h00};
    en_s = 1'b1;
    @(posedge clk); #1;
    en_s = 1'b0;
    for (int b = 0; b < n_beats; b++) begin
      g = b % S_RC;
      c = b / S_RC;
      for (int k = 0; k < S_IW; k++) begin
        if (mode == 0) lane = 8'(b * S_IW + k + 1);
        else if (mode == 1) lane = 8'($urandom);
        else lane = relu_pat[k];
        beat[k*8 +: 8] = lane;
        word[k*8 +: 8] = px_model(lane, g * S_IW + k, S_REAL);
      end
      gap = (gap_mode == 1) ? ((b > 0) ? 1 : 0) :
            (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      valid_s = 1'b1;
      data_s  = beat;
      if (b == en_at) en_s = 1'b1;
      @(negedge clk);
      tmo = 0;
      while (!ready_s && tmo < 20) begin
        @(negedge clk);
        tmo++;
      end
      if (!ready_s) begin
        chk("ready timeout", 512'(ready_s), 512'(1));
        valid_s = 1'b0;
        en_s    = 1'b0;
        return;
      end
      e.cyc  = cyc + 1;
      e.wren = 3'(1 << g);
      e.addr = 96'(c) << (g * 32);
      e.data = 96'(word) << (g * 32);
      exp_wr.push_back(e);
      if (b == S_N * S_RC - 1) exp_done.push_back(cyc + 2);
      @(posedge clk); #1;
      valid_s = 1'b0;
      en_s    = 1'b0;
    end
    if (en_in_done) begin
      @(posedge clk); #1;
      en_s = 1'b1;
      @(posedge clk); #1;
      en_s = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int tmo;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset wren", 512'(wren_s), 512'(0));
    chk("reset addr", 512'(addr_s), 512'(0));
    chk("reset data", 512'(wdata_s), 512'(0));
    chk("reset done", 512'(done_s), 512'(0));
    chk("reset busy", 512'(busy_s), 512'(0));
    chk("reset in_ready", 512'(ready_s), 512'(0));
    chk("reset f busy", 512'(f_busy), 512'(0));
    @(posedge clk); #1;

    run_row(0, 0, -1, 6, 1'b0);
    run_row(0, 1, -1, 6, 1'b0);

    run_row(0, 0, 3, 6, 1'b1);
    @(negedge clk);
    chk("idle busy after done-en", 512'(busy_s), 512'(0));
    chk("idle in_ready after done-en", 512'(ready_s), 512'(0));
    @(posedge clk); #1;
    run_row(0, 0, -1, 6, 1'b0);

    run_row(0, 0, -1, 4, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset wren", 512'(wren_s), 512'(0));
    chk("post-reset busy", 512'(busy_s), 512'(0));
    chk("post-reset in_ready", 512'(ready_s), 512'(0));
    chk("post-reset pending writes", 512'(exp_wr.size()), 512'(0));
    @(posedge clk); #1;
    run_row(0, 0, -1, 6, 1'b0);

    run_row(2, 0, -1, 6, 1'b0);
    repeat (6) run_row(1, 2, -1, 6, 1'b0);

    f_en = 1'b1;
    @(posedge clk); #1;
    f_en    = 1'b0;
    f_valid = 1'b1;
    for (int b = 0; b < F_RC * F_N; b++) begin
      logic [55:0] beat;
      logic [55:0] word;
      beat   = {24'($urandom), 32'($urandom)};
      f_data = beat;
      for (int k = 0; k < 7; k++) word[k*8 +: 8] = px_model(beat[k*8 +: 8], 0, 1);
      @(negedge clk);
      tmo = 0;
      while (!f_ready && tmo < 20) begin
        @(negedge clk);
        tmo++;
      end
      if (!f_ready) begin
        chk("f ready timeout", 512'(f_ready), 512'(1));
        break;
      end
      exp_fw.push_back(word);
      @(posedge clk); #1;
    end
    f_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < F_RC; i++) chk("f ram write count", 512'(f_cnt[i]), 512'(F_N));
    chk("f done count", 512'(f_done_cnt), 512'(1));
    chk("f busy at end", 512'(f_busy), 512'(0));
    chk("pending writes", 512'(exp_wr.size()), 512'(0));
    chk("pending dones", 512'(exp_done.size()), 512'(0));
    chk("f pending writes", 512'(exp_fw.size()), 512'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
